piezo_seq: RTL and testbench
============================

PIEZO_SEQ -- requirements
Module: piezo_seq

Interface
REQ-001 Parameter HALF_W, default 12: width of the tone half-period value and tone counter.
REQ-002 Parameter NOTE_TICKS, default 62500: clock cycles per note, legal range 2 to 2^NOTE_W-1.
REQ-003 Parameter NOTE_W, default 17: width of the note-duration counter.
REQ-004 Parameter SEQ_LEN, default 8: notes per melody, legal range 1 to 16.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 start  input  1  level, sampled each clock; requests playback while idle.
REQ-008 stop  input  1  level, sampled each clock; aborts playback.
REQ-009 mel_sel  input  1  melody select, latched at start acceptance.
REQ-010 loop_en  input  1  repeat melody when high, sampled at each end-of-melody boundary.
REQ-011 piezo  output  1  square-wave drive to piezo buzzer.
REQ-012 busy  output  1  high while in PLAY.
REQ-013 done  output  1  one-cycle pulse on natural (non-aborted) melody completion.
REQ-014 note_idx  output  4  index of the note currently playing.

Function
REQ-015 Two states, IDLE and PLAY; busy SHALL equal (state==PLAY).
REQ-016 IDLE: start=1 and stop=0 at an edge -> PLAY next cycle; latch mel_sel; note_idx=0; duration counter=0; tone counter=0; piezo=0.
REQ-017 IDLE with start=1 and stop=1 at the same edge -> stay IDLE; stop wins.
REQ-018 PLAY: start ignored; mel_sel changes ignored until the next start acceptance.
REQ-019 Tone table, half-period values, index 0..7; melody 0: 3846,3846,3048,2564,2564,1915,1915,1915; melody 1: 1915,0,1915,0,1915,0,1915,0.
REQ-020 Indices 8..15 SHALL read 0 (rest) for both melodies.
REQ-021 Tone generation in PLAY, each edge: if tone counter == tone value, toggle piezo and clear counter; else increment counter.
REQ-022 Consequence of REQ-021: half-period = tone+1 cycles.
REQ-023 Tone value 0 means rest: piezo held 0 and the tone counter held 0 for the whole note.
REQ-024 Duration counter counts 0..NOTE_TICKS-1 in PLAY.
REQ-025 At duration count NOTE_TICKS-1: duration counter -> 0, tone counter -> 0, piezo -> 0, note_idx -> next note.
REQ-026 Every note therefore lasts exactly NOTE_TICKS cycles and starts at phase low.
REQ-027 End of melody (boundary while note_idx==SEQ_LEN-1), loop_en=1: note_idx wraps to 0, stay PLAY, no done pulse.
REQ-028 End of melody, loop_en=0: -> IDLE, piezo=0, done=1 for exactly one cycle (first cycle with busy=0).
REQ-029 stop=1 in PLAY -> IDLE at that edge; piezo=0, counters cleared, note_idx=0, no done pulse.
REQ-030 stop SHALL take priority over end-of-melody when both occur at the same edge.
REQ-031 In IDLE: piezo=0, note_idx=0, counters held at 0, done=0 except the REQ-028 pulse.
REQ-032 Counter widths follow HALF_W and NOTE_W; counters SHALL never wrap, as they are bounded by the compares.

Reset
REQ-033 rst=1 asynchronously forces IDLE, piezo=0, busy=0, done=0, note_idx=0, and all counters and the latched melody to 0.
REQ-034 Reset asserted mid-PLAY SHALL abort with no done pulse.
REQ-035 First start is accepted at the first clock edge after rst deasserts.

Verification
REQ-036 Defaults, mel_sel=0, loop_en=0, one-cycle start -> busy rises next cycle; first piezo rise 3847 cycles after busy rises; piezo period 7694 cycles during notes 0-1.
REQ-037 Same run -> note_idx steps every 62500 cycles; busy high exactly 500000 cycles; single done pulse coincident with busy fall; piezo=0 afterward.
REQ-038 mel_sel=1, NOTE_TICKS=10000 -> odd notes show piezo constant 0 for 10000 cycles; even notes toggle every 1916 cycles.
REQ-039 loop_en=1, SEQ_LEN=4, NOTE_TICKS=10000 -> note_idx sequence 0,1,2,3,0,1...; no done; clearing loop_en before the idx-3 boundary -> IDLE with done pulse at 40000-cycle multiple.
REQ-040 stop mid-note 2 -> busy=0 and piezo=0 next cycle, no done; start and stop together in IDLE -> remains IDLE.
REQ-041 rst pulse (asynchronous, between edges) mid-PLAY -> outputs zero immediately without a clock edge; start after release replays from note 0.

Source files
------------

// File: rtl/piezo_seq.sv
// Two-melody piezo sequencer: plays SEQ_LEN notes of NOTE_TICKS cycles each,
// producing a square wave whose half-period is (tone value + 1) cycles.
module piezo_seq #(
    parameter int HALF_W     = 12,
    parameter int NOTE_TICKS = 62500,
    parameter int NOTE_W     = 17,
    parameter int SEQ_LEN    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       mel_sel,
    input  logic       loop_en,
    output logic       piezo,
    output logic       busy,
    output logic       done,
    output logic [3:0] note_idx
);

    typedef enum logic {IDLE, PLAY} state_t;

    localparam logic [NOTE_W-1:0] DUR_LAST = NOTE_W'(NOTE_TICKS - 1);
    localparam logic [3:0]        IDX_LAST = 4'(SEQ_LEN - 1);

    state_t              state_reg, state_next;
    logic                mel_reg, mel_next;
    logic                piezo_reg, piezo_next;
    logic                done_reg, done_next;
    logic [3:0]          idx_reg, idx_next;
    logic [NOTE_W-1:0]   dur_reg, dur_next;
    logic [HALF_W-1:0]   tone_reg, tone_next;
    logic [HALF_W-1:0]   tone_val;

    // Half-period table; a value of 0 marks a rest, upper indices are all rests.
    function automatic logic [HALF_W-1:0] tone_lookup(input logic mel, input logic [3:0] idx);
        logic [11:0] t;
        t = 12'd0;
        if (idx[3]) begin
            t = 12'd0;
        end else if (mel) begin
            t = idx[0] ? 12'd0 : 12'd1915;
        end else begin
            case (idx[2:0])
                3'd0, 3'd1: t = 12'd3846;
                3'd2:       t = 12'd3048;
                3'd3, 3'd4: t = 12'd2564;
                default:    t = 12'd1915;
            endcase
        end
        return HALF_W'(t);
    endfunction

    assign tone_val = tone_lookup(mel_reg, idx_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            mel_reg   <= 1'b0;
            piezo_reg <= 1'b0;
            done_reg  <= 1'b0;
            idx_reg   <= 4'd0;
            dur_reg   <= '0;
            tone_reg  <= '0;
        end else begin
            state_reg <= state_next;
            mel_reg   <= mel_next;
            piezo_reg <= piezo_next;
            done_reg  <= done_next;
            idx_reg   <= idx_next;
            dur_reg   <= dur_next;
            tone_reg  <= tone_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mel_next   = mel_reg;
        piezo_next = piezo_reg;
        done_next  = 1'b0;
        idx_next   = idx_reg;
        dur_next   = dur_reg;
        tone_next  = tone_reg;
        case (state_reg)
            IDLE: begin
                piezo_next = 1'b0;
                idx_next   = 4'd0;
                dur_next   = '0;
                tone_next  = '0;
                if (start && !stop) begin
                    state_next = PLAY;
                    mel_next   = mel_sel;
                end
            end
            PLAY: begin
                if (stop) begin
                    // Abort outranks the end-of-melody boundary on the same edge.
                    state_next = IDLE;
                    piezo_next = 1'b0;
                    idx_next   = 4'd0;
                    dur_next   = '0;
                    tone_next  = '0;
                end else if (dur_reg == DUR_LAST) begin
                    dur_next   = '0;
                    tone_next  = '0;
                    piezo_next = 1'b0;
                    if (idx_reg == IDX_LAST) begin
                        idx_next = 4'd0;
                        if (!loop_en) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end else begin
                    dur_next = dur_reg + 1'b1;
                    if (tone_val == '0) begin
                        tone_next  = '0;
                        piezo_next = 1'b0;
                    end else if (tone_reg == tone_val) begin
                        tone_next  = '0;
                        piezo_next = ~piezo_reg;
                    end else begin
                        tone_next = tone_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state_reg == PLAY);
    assign piezo    = piezo_reg;
    assign done     = done_reg;
    assign note_idx = idx_reg;

endmodule

// File: tb/tb_piezo_seq.sv
// Directed bench for piezo_seq: expected output snapshots are queued with their
// cycle number when stimulus is applied and compared when that cycle arrives.
module tb_piezo_seq;

    localparam int NT = 8000;
    localparam int SL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mel_sel = 1'b0;
    logic       loop_en = 1'b0;
    logic       piezo, busy, done;
    logic [3:0] note_idx;

    piezo_seq #(
        .HALF_W(12), .NOTE_TICKS(NT), .NOTE_W(17), .SEQ_LEN(SL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mel_sel(mel_sel),
        .loop_en(loop_en), .piezo(piezo), .busy(busy), .done(done), .note_idx(note_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        int         at;
        logic [6:0] exp;
    } exp_t;
    exp_t sb[$];

    // Snapshot layout: {busy, piezo, done, note_idx}
    function automatic logic [6:0] obs_vec();
        return {busy, piezo, done, note_idx};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_at(input string tag, input int at, input logic b, input logic p,
                             input logic d, input logic [3:0] i);
        exp_t e;
        e.tag = tag;
        e.at  = at;
        e.exp = {b, p, d, i};
        sb.push_back(e);
    endtask

    task automatic run_to(input int t);
        while (cyc < t) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk(e.tag, obs_vec(), e.exp);
            end
        end
    endtask

    task automatic pulse_start(input logic sel, output int b);
        chk("idle_pre_start", obs_vec(), 7'h00);
        start   = 1'b1;
        mel_sel = sel;
        @(negedge clk);
        start = 1'b0;
        b = cyc;
        chk("busy_rise", obs_vec(), {1'b1, 1'b0, 1'b0, 4'd0});
    endtask

    initial begin
        int b;
        int c;
        repeat (3) @(negedge clk);
        chk("reset_state", obs_vec(), 7'h00);
        rst = 1'b0;

        // Melody 0, no loop: first start right after reset release
        pulse_start(1'b0, b);
        expect_at("m0_pre_rise",  b + 3846,  1, 0, 0, 0);
        expect_at("m0_rise",      b + 3847,  1, 1, 0, 0);
        expect_at("m0_pre_fall",  b + 7693,  1, 1, 0, 0);
        expect_at("m0_fall",      b + 7694,  1, 0, 0, 0);
        expect_at("m0_note0_end", b + 7999,  1, 0, 0, 0);
        expect_at("m0_note1",     b + 8000,  1, 0, 0, 1);
        expect_at("m0_n1_rise",   b + 11847, 1, 1, 0, 1);
        expect_at("m0_last",      b + 15999, 1, 0, 0, 1);
        expect_at("m0_done",      b + 16000, 0, 0, 1, 0);
        expect_at("m0_done_clr",  b + 16001, 0, 0, 0, 0);
        run_to(b + 16005);

        // Melody 1 with mel_sel/start disturbed mid-play; stop lands on the final boundary
        pulse_start(1'b1, b);
        expect_at("m1_pre_rise",  b + 1915,  1, 0, 0, 0);
        expect_at("m1_rise",      b + 1916,  1, 1, 0, 0);
        expect_at("m1_fall",      b + 3832,  1, 0, 0, 0);
        expect_at("m1_rise2",     b + 5748,  1, 1, 0, 0);
        expect_at("m1_note0_end", b + 7999,  1, 0, 0, 0);
        expect_at("m1_note1",     b + 8000,  1, 0, 0, 1);
        expect_at("m1_rest_mid",  b + 12000, 1, 0, 0, 1);
        expect_at("m1_rest_end",  b + 15999, 1, 0, 0, 1);
        expect_at("m1_stop_prio", b + 16000, 0, 0, 0, 0);
        expect_at("m1_no_done",   b + 16001, 0, 0, 0, 0);
        run_to(b + 50);
        mel_sel = 1'b0;
        start   = 1'b1;
        run_to(b + 60);
        start = 1'b0;
        run_to(b + 15999);
        stop = 1'b1;
        run_to(b + 16001);
        stop = 1'b0;
        run_to(b + 16005);

        // Looping: wrap without done, then clear loop_en in the second pass
        loop_en = 1'b1;
        pulse_start(1'b0, b);
        expect_at("lp_note0_end", b + 7999,  1, 0, 0, 0);
        expect_at("lp_note1",     b + 8000,  1, 0, 0, 1);
        expect_at("lp_wrap",      b + 16000, 1, 0, 0, 0);
        expect_at("lp_wrap_nodn", b + 16001, 1, 0, 0, 0);
        expect_at("lp_pre_rise",  b + 19846, 1, 0, 0, 0);
        expect_at("lp_rise",      b + 19847, 1, 1, 0, 0);
        expect_at("lp_note1_b",   b + 24000, 1, 0, 0, 1);
        expect_at("lp_done",      b + 32000, 0, 0, 1, 0);
        expect_at("lp_done_clr",  b + 32001, 0, 0, 0, 0);
        run_to(b + 28000);
        loop_en = 1'b0;
        run_to(b + 32005);

        // Stop mid-note while piezo is high, then start+stop together in IDLE
        pulse_start(1'b0, b);
        expect_at("st_before",    b + 4000, 1, 1, 0, 0);
        expect_at("st_abort",     b + 4001, 0, 0, 0, 0);
        expect_at("st_no_done",   b + 4002, 0, 0, 0, 0);
        run_to(b + 4000);
        stop = 1'b1;
        run_to(b + 4002);
        stop  = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        c = cyc;
        expect_at("ss_idle1", c + 1, 0, 0, 0, 0);
        expect_at("ss_idle2", c + 2, 0, 0, 0, 0);
        run_to(c + 3);
        start = 1'b0;
        stop  = 1'b0;
        run_to(c + 5);

        // Asynchronous reset between edges mid-play, then replay from note 0
        pulse_start(1'b0, b);
        expect_at("ar_rise", b + 3847, 1, 1, 0, 0);
        run_to(b + 4000);
        #2 rst = 1'b1;
        #1 chk("async_reset", obs_vec(), 7'h00);
        @(negedge clk);
        chk("reset_hold", obs_vec(), 7'h00);
        rst = 1'b0;
        pulse_start(1'b0, b);
        expect_at("rp_pre_rise", b + 3846, 1, 0, 0, 0);
        expect_at("rp_rise",     b + 3847, 1, 1, 0, 0);
        expect_at("rp_abort",    b + 3852, 0, 0, 0, 0);
        run_to(b + 3850);
        stop = 1'b1;
        run_to(b + 3852);
        stop = 1'b0;
        run_to(b + 3854);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_drained observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
